// File: rtl/usb_sipo_deframer_pkg.sv
// Shared constants and FSM encoding for the USB receive-path SIPO deframer.
package usb_sipo_deframer_pkg;

  // Consecutive 1s after which the transmitter inserts a stuff bit.
  localparam int unsigned StuffRun = 6;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StFlush,
    StDone
  } sipo_state_e;

endpackage

// File: rtl/usb_sipo_deframer_unstuffer.sv
// Bit unstuffer: tracks runs of accepted 1s and flags the stuff slot that follows a full run.
module usb_bit_unstuffer
  import usb_sipo_deframer_pkg::*;
#(
  parameter bit STUFF_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic bit_in,
  input  logic bit_val,
  output logic data_val,
  output logic stuff_err
);

  logic [2:0] ones_run_q, ones_run_d;
  logic       stuff_slot;

  assign stuff_slot = (STUFF_EN != 1'b0) && (ones_run_q == 3'(StuffRun));
  assign data_val   = bit_val & ~stuff_slot;
  assign stuff_err  = bit_val & stuff_slot & bit_in;

  always_comb begin
    ones_run_d = ones_run_q;
    if (clear) begin
      ones_run_d = '0;
    end else if (bit_val) begin
      // The stuff slot always restarts the run, whatever value it carries.
      if (stuff_slot || !bit_in) begin
        ones_run_d = '0;
      end else if (ones_run_q != 3'(StuffRun)) begin
        ones_run_d = ones_run_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ones_run_q <= '0;
    end else begin
      ones_run_q <= ones_run_d;
    end
  end

endmodule

// File: rtl/usb_sipo_deframer.sv
// Unstuffs the decoded serial stream, assembles LSB-first bytes and writes them to the receive fifo.
module usb_sipo_deframer
  import usb_sipo_deframer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned MAX_PKT_BYTES = 1027,
  parameter int unsigned CNT_WIDTH     = 11,
  parameter bit          STUFF_EN      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  serial_in,
  input  logic                  serial_in_val,
  input  logic                  serial_in_last,
  output logic                  sipo_empty,
  output logic [DATA_WIDTH-1:0] fifo_w_data,
  output logic                  fifo_wr_en,
  input  logic                  fifo_full,
  output logic                  pkt_done,
  output logic [CNT_WIDTH-1:0]  pkt_byte_count,
  output logic                  pkt_err,
  output logic                  err_stuff,
  output logic                  err_align,
  output logic                  err_ovf
);

  localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  sipo_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] shift_q, shift_next, hold_q;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_next, bit_cnt_d;
  logic [CNT_WIDTH-1:0]  byte_cnt_q, byte_cnt_d;
  logic [CNT_WIDTH:0]    accepted;
  logic hold_valid_q, hold_valid_d, sticky_q, sticky_d;
  logic err_stuff_q, err_align_q, err_ovf_q;
  logic accept, clear, data_bit, stuff_err, byte_done, last_seen, at_max;
  logic load, align_err, ovf_err;

  assign accept = serial_in_val & ((state_q == StIdle) | (state_q == StRecv));
  assign clear  = (state_q == StDone);

  usb_bit_unstuffer #(
    .STUFF_EN (STUFF_EN)
  ) u_unstuffer (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .bit_in    (serial_in),
    .bit_val   (accept),
    .data_val  (data_bit),
    .stuff_err (stuff_err)
  );

  // Bytes already committed (written plus held) bound the packet length.
  assign accepted   = {1'b0, byte_cnt_q} + (CNT_WIDTH + 1)'(hold_valid_q);
  assign at_max     = accepted >= (CNT_WIDTH + 1)'(MAX_PKT_BYTES);
  assign shift_next = {serial_in, shift_q[DATA_WIDTH-1:1]};
  assign byte_done  = data_bit & (bit_cnt_q == BitCntW'(DATA_WIDTH - 1));
  assign load       = byte_done & ~at_max & (~hold_valid_q | fifo_wr_en);
  assign ovf_err    = (byte_done & (at_max | (hold_valid_q & ~fifo_wr_en)))
                    | ((state_q == StFlush) & serial_in_val);

  assign bit_cnt_next = !data_bit ? bit_cnt_q : byte_done ? '0 : bit_cnt_q + BitCntW'(1);
  assign last_seen    = accept & serial_in_last;
  assign align_err    = last_seen & (bit_cnt_next != '0);
  assign bit_cnt_d    = (last_seen || clear) ? '0 : bit_cnt_next;

  assign hold_valid_d = load | (hold_valid_q & ~fifo_wr_en);
  assign byte_cnt_d   = clear ? '0 : byte_cnt_q + CNT_WIDTH'(fifo_wr_en);
  assign sticky_d     = clear ? 1'b0 : (sticky_q | stuff_err | align_err | ovf_err);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StRecv: begin
        if (accept) begin
          if (serial_in_last) begin
            state_d = hold_valid_d ? StFlush : StDone;
          end else begin
            state_d = StRecv;
          end
        end
      end
      StFlush: if (fifo_wr_en) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fifo_wr_en     = hold_valid_q & ~fifo_full;
    fifo_w_data    = hold_q;
    sipo_empty     = (state_q == StIdle) & ~hold_valid_q;
    pkt_done       = (state_q == StDone);
    pkt_byte_count = pkt_done ? byte_cnt_q : '0;
    pkt_err        = pkt_done & sticky_q;
    err_stuff      = err_stuff_q;
    err_align      = err_align_q;
    err_ovf        = err_ovf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      byte_cnt_q   <= '0;
      sticky_q     <= 1'b0;
      err_stuff_q  <= 1'b0;
      err_align_q  <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      if (data_bit) shift_q <= shift_next;
      if (load) hold_q <= shift_next;
      bit_cnt_q    <= bit_cnt_d;
      hold_valid_q <= hold_valid_d;
      byte_cnt_q   <= byte_cnt_d;
      sticky_q     <= sticky_d;
      err_stuff_q  <= stuff_err;
      err_align_q  <= align_err;
      err_ovf_q    <= ovf_err;
    end
  end

endmodule

// File: tb/tb_usb_sipo_deframer.sv
// Self-checking bench for usb_sipo_deframer: directed table, corner sequences and random packets.
module tb_usb_sipo_deframer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        serial_in = 1'b0, serial_in_val = 1'b0, serial_in_last = 1'b0;
  logic        fifo_full = 1'b0;
  logic        sipo_empty, fifo_wr_en, pkt_done, pkt_err, err_stuff, err_align, err_ovf;
  logic [7:0]  fifo_w_data;
  logic [10:0] pkt_byte_count;

  usb_sipo_deframer dut (
    .clk            (clk),
    .rst            (rst),
    .serial_in      (serial_in),
    .serial_in_val  (serial_in_val),
    .serial_in_last (serial_in_last),
    .sipo_empty     (sipo_empty),
    .fifo_w_data    (fifo_w_data),
    .fifo_wr_en     (fifo_wr_en),
    .fifo_full      (fifo_full),
    .pkt_done       (pkt_done),
    .pkt_byte_count (pkt_byte_count),
    .pkt_err        (pkt_err),
    .err_stuff      (err_stuff),
    .err_align      (err_align),
    .err_ovf        (err_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic [7:0] got[$];
  int   dcnt[$];
  logic derr[$];
  int   n_stuff, n_align, n_ovf, wr_cyc, done_cyc;

  always @(negedge clk) begin
    if (fifo_wr_en) begin
      got.push_back(fifo_w_data);
      wr_cyc = cyc;
    end
    if (pkt_done) begin
      dcnt.push_back(int'(pkt_byte_count));
      derr.push_back(pkt_err);
      done_cyc = cyc;
    end
    n_stuff += int'(err_stuff);
    n_align += int'(err_align);
    n_ovf   += int'(err_ovf);
  end

  bit         tx[$];
  logic [7:0] exp_b[$];
  int         exp_stuff, exp_align;

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    int          cnt;
    bit          err;
    int          nstuff;
    int          nalign;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input bit b, input bit last);
    serial_in      = b;
    serial_in_val  = 1'b1;
    serial_in_last = last;
    @(posedge clk);
    #1;
    serial_in_val  = 1'b0;
    serial_in_last = 1'b0;
  endtask

  task automatic send(input int max_gap);
    foreach (tx[i]) begin
      repeat ($urandom_range(max_gap)) idle();
      drive_bit(tx[i], i == tx.size() - 1);
    end
  endtask

  task automatic clear_mon();
    got.delete();
    dcnt.delete();
    derr.delete();
    n_stuff = 0;
    n_align = 0;
    n_ovf   = 0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && dcnt.size() == 0; i++) @(negedge clk);
    idle();
    repeat (2) idle();
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int j = 0; j < 8; j++) tx.push_back(b[j]);
  endtask

  // Reference: drop the slot after every six 1s, then cut the data bits into LSB-first bytes.
  task automatic model_pkt();
    int run;
    bit data[$];
    logic [7:0] b;
    run = 0;
    exp_b.delete();
    exp_stuff = 0;
    exp_align = 0;
    foreach (tx[i]) begin
      if (run == 6) begin
        if (tx[i]) exp_stuff++;
        run = 0;
      end else begin
        data.push_back(tx[i]);
        run = tx[i] ? run + 1 : 0;
      end
    end
    for (int k = 0; k + 8 <= data.size(); k += 8) begin
      for (int j = 0; j < 8; j++) b[j] = data[k + j];
      exp_b.push_back(b);
    end
    if (data.size() % 8 != 0) exp_align = 1;
  endtask

  // Random stuffed stream; a stuff bit is occasionally corrupted to 1.
  task automatic gen_pkt(input int nbytes, input bit inject, input int trunc);
    int run;
    logic [7:0] b;
    run = 0;
    tx.delete();
    for (int k = 0; k < nbytes; k++) begin
      b = ($urandom_range(1) == 0) ? 8'hFF : 8'($urandom);
      for (int j = 0; j < 8; j++) begin
        tx.push_back(b[j]);
        run = b[j] ? run + 1 : 0;
        if (run == 6) begin
          tx.push_back(inject && ($urandom_range(3) == 0));
          run = 0;
        end
      end
    end
    repeat (trunc) void'(tx.pop_back());
  endtask

  task automatic check_pkt(input string tag, input bit e_err, input int e_ovf);
    chk($sformatf("%s done_count", tag), dcnt.size(), 1);
    if (dcnt.size() > 0) begin
      chk($sformatf("%s byte_count", tag), dcnt[0], exp_b.size());
      chk($sformatf("%s pkt_err", tag), derr[0], e_err);
    end
    chk($sformatf("%s n_writes", tag), got.size(), exp_b.size());
    for (int i = 0; i < got.size() && i < exp_b.size(); i++)
      chk($sformatf("%s byte%0d", tag, i), got[i], exp_b[i]);
    chk($sformatf("%s err_stuff", tag), n_stuff, exp_stuff);
    chk($sformatf("%s err_align", tag), n_align, exp_align);
    chk($sformatf("%s err_ovf", tag), n_ovf, e_ovf);
    chk($sformatf("%s sipo_empty", tag), sipo_empty, 1);
  endtask

  initial begin
    tbl[0] = '{32'h0A5,  8, 1, 1'b0, 0, 0, 8'hA5, 8'h00};
    tbl[1] = '{32'h1BF, 17, 2, 1'b0, 0, 0, 8'hFF, 8'h00};
    tbl[2] = '{32'h1FF, 17, 2, 1'b1, 1, 0, 8'hFF, 8'h00};
    tbl[3] = '{32'h015,  5, 0, 1'b1, 0, 1, 8'h00, 8'h00};

    clear_mon();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset sipo_empty", sipo_empty, 1);
    chk("reset fifo_wr_en", fifo_wr_en, 0);
    chk("reset fifo_w_data", fifo_w_data, 0);
    chk("reset pkt_done", pkt_done, 0);
    chk("reset pkt_byte_count", pkt_byte_count, 0);
    chk("reset pkt_err", pkt_err, 0);
    chk("reset err_pulses", {err_stuff, err_align, err_ovf}, 0);
    idle();

    foreach (tbl[t]) begin
      clear_mon();
      tx.delete();
      for (int i = 0; i < tbl[t].nbits; i++) tx.push_back(tbl[t].bits[i]);
      send(0);
      wait_done(100);
      exp_b.delete();
      if (tbl[t].cnt > 0) exp_b.push_back(tbl[t].b0);
      if (tbl[t].cnt > 1) exp_b.push_back(tbl[t].b1);
      exp_stuff = tbl[t].nstuff;
      exp_align = tbl[t].nalign;
      check_pkt($sformatf("vec%0d", t), tbl[t].err, 0);
    end

    // Two bytes arrive while the fifo is full; the second cannot be held.
    clear_mon();
    tx.delete();
    push_byte(8'h11);
    push_byte(8'h22);
    fifo_full = 1'b1;
    send(0);
    repeat (4) idle();
    fifo_full = 1'b0;
    wait_done(100);
    exp_b = '{8'h11};
    exp_stuff = 0;
    exp_align = 0;
    check_pkt("full_stall", 1'b1, 1);

    // Reset mid-packet, then a clean packet.
    clear_mon();
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    repeat (4) idle();
    chk("abort no_done", dcnt.size(), 0);
    chk("abort sipo_empty", sipo_empty, 1);
    tx.delete();
    push_byte(8'h3C);
    send(0);
    wait_done(100);
    exp_b = '{8'h3C};
    check_pkt("after_abort", 1'b0, 0);

    // Last bit completes a byte while the fifo is full: deferred flush.
    clear_mon();
    tx.delete();
    push_byte(8'h5A);
    fifo_full = 1'b1;
    send(0);
    @(negedge clk);
    chk("flush sipo_empty", sipo_empty, 0);
    chk("flush wr_en", fifo_wr_en, 0);
    idle();
    repeat (5) idle();
    chk("flush no_done", dcnt.size(), 0);
    fifo_full = 1'b0;
    wait_done(100);
    chk("flush done_latency", done_cyc - wr_cyc, 1);
    exp_b = '{8'h5A};
    check_pkt("flush", 1'b0, 0);

    for (int p = 0; p < 25; p++) begin
      clear_mon();
      gen_pkt($urandom_range(5, 1), 1'b1,
              ($urandom_range(3) == 0) ? $urandom_range(7, 1) : 0);
      send($urandom_range(2));
      wait_done(400);
      model_pkt();
      check_pkt($sformatf("rnd%0d", p), (exp_stuff > 0) || (exp_align != 0), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
